// File: rtl/pixel_generator_pkg.sv
// Shared types, default geometry and the colour pattern for the test-pattern source.
// Optional build macro: PIXEL_GENERATOR_FRAME_ANIM_EN
//   defined   -> red channel scrolls by the frame counter (R = x + frame)
//   undefined -> static pattern (R = x)
package pixel_generator_pkg;

  localparam int DEFAULT_WIDTH  = 640;
  localparam int DEFAULT_HEIGHT = 480;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Colour of pixel (x,y) in a given frame; all channels wrap modulo 256.
  function automatic rgb_t pattern(input logic [7:0] x,
                                   input logic [7:0] y,
                                   input logic [7:0] frame);
    rgb_t p;
`ifdef PIXEL_GENERATOR_FRAME_ANIM_EN
    p.r = x + frame;
`else
    // frame stays in the signature so both builds share one call site;
    // it is masked off so it cannot affect the static pattern.
    p.r = x | (frame & 8'h00);
`endif
    p.g = y;
    p.b = x ^ y;
    return p;
  endfunction

endpackage

// File: rtl/pixel_generator_raster_counter.sv
// Raster position and frame counter for the pixel generator.
// x/y/frame outputs report the coordinates the pixel register will hold after
// the coming clock edge, so the top can register the pattern with no extra lag.
// last_pixel flags that the currently held position is the last one of a frame.
module raster_counter #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int XW     = $clog2(WIDTH),
  parameter int YW     = $clog2(HEIGHT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          advance,
  input  logic          restart,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [7:0]    frame,
  output logic          last_pixel
);

  logic [XW-1:0] x_r;
  logic [YW-1:0] y_r;
  logic [7:0]    frame_r;

  logic [XW-1:0] x_nxt_s;
  logic [YW-1:0] y_nxt_s;
  logic [7:0]    frame_nxt_s;
  logic          x_last_s;
  logic          y_last_s;

  // End-of-line / end-of-frame detection on the held position.
  always_comb begin
    x_last_s   = (x_r == XW'(WIDTH - 1));
    y_last_s   = (y_r == YW'(HEIGHT - 1));
    last_pixel = x_last_s & y_last_s;
  end

  // Next raster position: restart wins over a normal advance.
  always_comb begin
    x_nxt_s     = x_r;
    y_nxt_s     = y_r;
    frame_nxt_s = frame_r;
    if (restart) begin
      x_nxt_s     = {XW{1'b0}};
      y_nxt_s     = {YW{1'b0}};
      frame_nxt_s = frame_r + 8'd1;
    end else if (advance) begin
      if (x_last_s) begin
        x_nxt_s = {XW{1'b0}};
        if (y_last_s) begin
          y_nxt_s     = {YW{1'b0}};
          frame_nxt_s = frame_r + 8'd1;
        end else begin
          y_nxt_s = y_r + YW'(1);
        end
      end else begin
        x_nxt_s = x_r + XW'(1);
      end
    end else begin
      x_nxt_s     = x_r;
      y_nxt_s     = y_r;
      frame_nxt_s = frame_r;
    end
  end

  // Counter state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_r     <= {XW{1'b0}};
      y_r     <= {YW{1'b0}};
      frame_r <= 8'd0;
    end else begin
      x_r     <= x_nxt_s;
      y_r     <= y_nxt_s;
      frame_r <= frame_nxt_s;
    end
  end

  // Expose the upcoming position to the output register.
  always_comb begin
    x     = x_nxt_s;
    y     = y_nxt_s;
    frame = frame_nxt_s;
  end

endmodule

// File: rtl/pixel_generator.sv
// Free-running raster test-pattern source with a valid/ready output stream.
// Optional build macro: PIXEL_GENERATOR_FRAME_ANIM_EN (frame-scrolled red channel).
// All outputs come straight from registers; the raster counter supplies the
// coordinates of the pixel to present after each edge.
module pixel_generator
  import pixel_generator_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int HEIGHT = DEFAULT_HEIGHT,
  parameter int XW     = $clog2(WIDTH),
  parameter int YW     = $clog2(HEIGHT)
) (
  input  logic        in_clk,
  input  logic        in_reset,
  input  logic        in_next_frame,
  output logic [23:0] out_pixel_data,
  output logic        out_pixel_valid,
  input  logic        out_pixel_ready,
  output logic        out_pixel_sof,
  output logic        out_pixel_eol
);

  logic          valid_r;
  rgb_t          data_r;
  logic          sof_r;
  logic          eol_r;

  logic          advance_s;
  logic          restart_s;
  logic [XW-1:0] x_s;
  logic [YW-1:0] y_s;
  logic [7:0]    frame_s;
  logic          last_pixel_s;
  logic          sof_nxt_s;
  logic          eol_nxt_s;
  rgb_t          pix_s;

  raster_counter #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT),
    .XW    (XW),
    .YW    (YW)
  ) u_raster (
    .clk       (in_clk),
    .rst       (in_reset),
    .advance   (advance_s),
    .restart   (restart_s),
    .x         (x_s),
    .y         (y_s),
    .frame     (frame_s),
    .last_pixel(last_pixel_s)
  );

  // Handshake decode: restart drops the presented pixel and beats any transfer;
  // nothing moves while the first pixel is still being loaded after reset.
  always_comb begin
    restart_s = 1'b0;
    advance_s = 1'b0;
    if (valid_r) begin
      restart_s = in_next_frame;
      advance_s = out_pixel_ready & ~in_next_frame;
    end else begin
      restart_s = 1'b0;
      advance_s = 1'b0;
    end
  end

  // Flags and colour for the pixel presented after the coming edge.
  always_comb begin
    sof_nxt_s = sof_r;
    if (!valid_r) begin
      sof_nxt_s = 1'b1;
    end else if (restart_s) begin
      sof_nxt_s = 1'b1;
    end else if (advance_s) begin
      sof_nxt_s = last_pixel_s;
    end else begin
      sof_nxt_s = sof_r;
    end
    eol_nxt_s = (x_s == XW'(WIDTH - 1));
    pix_s     = pattern(8'(x_s), 8'(y_s), frame_s);
  end

  // Output register; the source never runs dry so valid stays high after reset.
  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      valid_r <= 1'b0;
      data_r  <= '{r: 8'h00, g: 8'h00, b: 8'h00};
      sof_r   <= 1'b0;
      eol_r   <= 1'b0;
    end else begin
      valid_r <= 1'b1;
      data_r  <= pix_s;
      sof_r   <= sof_nxt_s;
      eol_r   <= eol_nxt_s;
    end
  end

  // Drive ports from the registers.
  always_comb begin
    out_pixel_valid = valid_r;
    out_pixel_data  = data_r;
    out_pixel_sof   = sof_r;
    out_pixel_eol   = eol_r;
  end

endmodule

// File: tb/tb_pixel_generator.sv
// Directed, table-driven bench for pixel_generator on a 4x3 raster.
module tb_pixel_generator;

  logic        clk;
  logic        in_reset;
  logic        in_next_frame;
  logic [23:0] out_pixel_data;
  logic        out_pixel_valid;
  logic        out_pixel_ready;
  logic        out_pixel_sof;
  logic        out_pixel_eol;

  int n_checks;
  int n_fail;

  typedef struct {
    logic        ready;
    logic        nf;
    logic [23:0] data;   // static-pattern colour
    logic [7:0]  frame;  // frame number of the expected pixel
    logic        sof;
    logic        eol;
  } vec_t;

  vec_t vecs[$];

  pixel_generator #(
    .WIDTH (4),
    .HEIGHT(3)
  ) dut (
    .in_clk         (clk),
    .in_reset       (in_reset),
    .in_next_frame  (in_next_frame),
    .out_pixel_data (out_pixel_data),
    .out_pixel_valid(out_pixel_valid),
    .out_pixel_ready(out_pixel_ready),
    .out_pixel_sof  (out_pixel_sof),
    .out_pixel_eol  (out_pixel_eol)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected colour given the static colour and the frame number.
  function automatic logic [23:0] exp_rgb(input logic [23:0] d, input logic [7:0] f);
`ifdef PIXEL_GENERATOR_FRAME_ANIM_EN
    logic [7:0] r;
    r = d[23:16] + f;
    return {r, d[15:0]};
`else
    return {d[23:16] | (f & 8'h00), d[15:0]};
`endif
  endfunction

  task automatic check(input string name, input logic exp_valid, input logic [23:0] exp_data,
                       input logic exp_sof, input logic exp_eol);
    n_checks++;
    if ({out_pixel_valid, out_pixel_data, out_pixel_sof, out_pixel_eol} !==
        {exp_valid, exp_data, exp_sof, exp_eol}) begin
      n_fail++;
      $display("FAIL %s: got valid=%0b data=%06h sof=%0b eol=%0b, expected valid=%0b data=%06h sof=%0b eol=%0b",
               name, out_pixel_valid, out_pixel_data, out_pixel_sof, out_pixel_eol,
               exp_valid, exp_data, exp_sof, exp_eol);
    end
  endtask

  task automatic add(input logic ready, input logic nf, input logic [23:0] data,
                     input logic [7:0] frame, input logic sof, input logic eol);
    vec_t v;
    v.ready = ready; v.nf = nf; v.data = data; v.frame = frame; v.sof = sof; v.eol = eol;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // Handshake and hold, then a full 4x3 frame at one pixel per clock.
    add(1'b1, 1'b0, 24'h010001, 8'd0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 24'h010001, 8'd0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 24'h010001, 8'd0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 24'h020002, 8'd0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 24'h030003, 8'd0, 1'b0, 1'b1);
    add(1'b1, 1'b0, 24'h000101, 8'd0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 24'h010100, 8'd0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 24'h020103, 8'd0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 24'h030102, 8'd0, 1'b0, 1'b1);
    add(1'b1, 1'b0, 24'h000202, 8'd0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 24'h010203, 8'd0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 24'h020200, 8'd0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 24'h030201, 8'd0, 1'b0, 1'b1);
    add(1'b1, 1'b0, 24'h000000, 8'd1, 1'b1, 1'b0);  // natural wrap into frame 1
    // Frame 1 up to (2,1), then restart without acceptance.
    add(1'b1, 1'b0, 24'h010001, 8'd1, 1'b0, 1'b0);
    add(1'b1, 1'b0, 24'h020002, 8'd1, 1'b0, 1'b0);
    add(1'b1, 1'b0, 24'h030003, 8'd1, 1'b0, 1'b1);
    add(1'b1, 1'b0, 24'h000101, 8'd1, 1'b0, 1'b0);
    add(1'b1, 1'b0, 24'h010100, 8'd1, 1'b0, 1'b0);
    add(1'b1, 1'b0, 24'h020103, 8'd1, 1'b0, 1'b0);
    add(1'b0, 1'b1, 24'h000000, 8'd2, 1'b1, 1'b0);  // restart while stalled
    // Frame 2 to its last pixel, then restart coinciding with transfer + wrap.
    add(1'b1, 1'b0, 24'h010001, 8'd2, 1'b0, 1'b0);
    add(1'b1, 1'b0, 24'h020002, 8'd2, 1'b0, 1'b0);
    add(1'b1, 1'b0, 24'h030003, 8'd2, 1'b0, 1'b1);
    add(1'b1, 1'b0, 24'h000101, 8'd2, 1'b0, 1'b0);
    add(1'b1, 1'b0, 24'h010100, 8'd2, 1'b0, 1'b0);
    add(1'b1, 1'b0, 24'h020103, 8'd2, 1'b0, 1'b0);
    add(1'b1, 1'b0, 24'h030102, 8'd2, 1'b0, 1'b1);
    add(1'b1, 1'b0, 24'h000202, 8'd2, 1'b0, 1'b0);
    add(1'b1, 1'b0, 24'h010203, 8'd2, 1'b0, 1'b0);
    add(1'b1, 1'b0, 24'h020200, 8'd2, 1'b0, 1'b0);
    add(1'b1, 1'b0, 24'h030201, 8'd2, 1'b0, 1'b1);
    add(1'b1, 1'b1, 24'h000000, 8'd3, 1'b1, 1'b0);  // single increment, not two
    add(1'b1, 1'b0, 24'h010001, 8'd3, 1'b0, 1'b0);
    add(1'b1, 1'b0, 24'h020002, 8'd3, 1'b0, 1'b0);

    // Reset for one cycle with ready low.
    in_reset        = 1'b1;
    in_next_frame   = 1'b0;
    out_pixel_ready = 1'b0;
    tick();
    check("reset_state", 1'b0, 24'h000000, 1'b0, 1'b0);
    in_reset = 1'b0;
    tick();
    check("first_pixel", 1'b1, 24'h000000, 1'b1, 1'b0);
    tick();
    check("first_pixel_hold", 1'b1, 24'h000000, 1'b1, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      out_pixel_ready = vecs[i].ready;
      in_next_frame   = vecs[i].nf;
      tick();
      check($sformatf("vec%0d", i), 1'b1, exp_rgb(vecs[i].data, vecs[i].frame),
            vecs[i].sof, vecs[i].eol);
    end
    in_next_frame   = 1'b0;
    out_pixel_ready = 1'b0;

    // Asynchronous reset mid-line: outputs clear before any clock edge.
    #2;
    in_reset = 1'b1;
    #1;
    check("async_reset", 1'b0, 24'h000000, 1'b0, 1'b0);
    tick();
    check("reset_hold", 1'b0, 24'h000000, 1'b0, 1'b0);
    // Release with next_frame and ready high: both ignored while valid is low.
    in_reset        = 1'b0;
    in_next_frame   = 1'b1;
    out_pixel_ready = 1'b1;
    tick();
    check("restart_after_reset", 1'b1, 24'h000000, 1'b1, 1'b0);
    in_next_frame = 1'b0;
    tick();
    check("frame0_after_reset", 1'b1, exp_rgb(24'h010001, 8'd0), 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
